// File: rtl/vending_machine_multi.sv
// Multi-item vending controller: accumulates 5/10/25 coins as credit, vends one of NUM_ITEMS
// products at a per-item price, tracks stock, and pays change one coin per cycle.
module vending_machine_multi #(
    parameter int NUM_ITEMS = 4,
    parameter int CREDIT_W = 8,
    parameter int MAX_CREDIT = 40,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {8'd5, 8'd4, 8'd3, 8'd2},
    parameter int STOCK_W = 4,
    parameter int INIT_STOCK = 15,
    localparam int IDX_W = $clog2(NUM_ITEMS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 coin_valid,
    input  logic [1:0]           coin_type,
    input  logic                 sel_valid,
    input  logic [IDX_W-1:0]     sel_idx,
    input  logic                 cancel,
    input  logic                 restock,
    output logic                 vend_valid,
    output logic [IDX_W-1:0]     vend_idx,
    output logic                 change_valid,
    output logic [1:0]           change_coin,
    output logic                 coin_reject,
    output logic                 deny,
    output logic                 busy,
    output logic [CREDIT_W-1:0]  credit,
    output logic [NUM_ITEMS-1:0] sold_out
);

    typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

    localparam logic [CREDIT_W-1:0] MAX_C  = CREDIT_W'(MAX_CREDIT);
    localparam logic [STOCK_W-1:0]  INIT_S = STOCK_W'(INIT_STOCK);

    state_t               state, state_nxt;
    logic [CREDIT_W-1:0]  credit_nxt;
    logic [CREDIT_W-1:0]  coin_val;
    logic [CREDIT_W-1:0]  change_val;
    logic [CREDIT_W-1:0]  price_sel;
    logic [CREDIT_W-1:0]  price_vend;
    logic [IDX_W-1:0]     idx_nxt;
    logic [1:0]           coin_nxt;
    logic                 reject_nxt;
    logic                 deny_nxt;
    logic                 dec_stock;
    logic [STOCK_W-1:0]   stock [NUM_ITEMS];
    logic [CREDIT_W-1:0]  price_tab [NUM_ITEMS];

    for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_item
        assign price_tab[i] = PRICES[i*CREDIT_W +: CREDIT_W];
        assign sold_out[i]  = (stock[i] == '0);
    end

    assign price_sel  = price_tab[sel_idx];
    assign price_vend = price_tab[vend_idx];

    always_comb begin
        case (coin_type)
            2'b00:   coin_val = CREDIT_W'(1);
            2'b01:   coin_val = CREDIT_W'(2);
            default: coin_val = CREDIT_W'(5);
        endcase
        case (change_coin)
            2'b00:   change_val = CREDIT_W'(1);
            2'b01:   change_val = CREDIT_W'(2);
            default: change_val = CREDIT_W'(5);
        endcase
    end

    always_comb begin
        state_nxt  = state;
        credit_nxt = credit;
        idx_nxt    = vend_idx;
        reject_nxt = 1'b0;
        deny_nxt   = 1'b0;
        dec_stock  = 1'b0;
        case (state)
            IDLE: begin
                if (cancel) begin
                    reject_nxt = coin_valid;
                    if (credit != '0)
                        state_nxt = CHANGE;
                end else if (sel_valid) begin
                    reject_nxt = coin_valid;
                    if (credit >= price_sel && !sold_out[sel_idx]) begin
                        state_nxt = VEND;
                        idx_nxt   = sel_idx;
                    end else begin
                        deny_nxt = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (coin_type == 2'b11 || (credit + coin_val) > MAX_C)
                        reject_nxt = 1'b1;
                    else
                        credit_nxt = credit + coin_val;
                end
            end
            VEND: begin
                reject_nxt = coin_valid;
                dec_stock  = 1'b1;
                credit_nxt = credit - price_vend;
                state_nxt  = (credit_nxt != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                reject_nxt = coin_valid;
                credit_nxt = credit - change_val;
                state_nxt  = (credit_nxt == '0) ? IDLE : CHANGE;
            end
            default: state_nxt = IDLE;
        endcase

        // Coin for the upcoming CHANGE cycle is chosen from the credit it will see.
        coin_nxt = 2'b00;
        if (state_nxt == CHANGE) begin
            if (credit_nxt >= CREDIT_W'(5))
                coin_nxt = 2'b10;
            else if (credit_nxt >= CREDIT_W'(2))
                coin_nxt = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            credit       <= '0;
            vend_idx     <= '0;
            vend_valid   <= 1'b0;
            change_valid <= 1'b0;
            change_coin  <= 2'b00;
            coin_reject  <= 1'b0;
            deny         <= 1'b0;
            busy         <= 1'b0;
            for (int i = 0; i < NUM_ITEMS; i++)
                stock[i] <= INIT_S;
        end else begin
            state        <= state_nxt;
            credit       <= credit_nxt;
            vend_idx     <= idx_nxt;
            vend_valid   <= (state_nxt == VEND);
            change_valid <= (state_nxt == CHANGE);
            change_coin  <= coin_nxt;
            coin_reject  <= reject_nxt;
            deny         <= deny_nxt;
            busy         <= (state_nxt != IDLE);
            // Restock overrides a coincident vend decrement.
            if (restock) begin
                for (int i = 0; i < NUM_ITEMS; i++)
                    stock[i] <= INIT_S;
            end else if (dec_stock && stock[vend_idx] != '0) begin
                stock[vend_idx] <= stock[vend_idx] - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vending_machine_multi.sv
// Randomized and directed bench for vending_machine_multi against a transaction-level model
// that plans each sale or refund as a list of dispense/coin actions.
module tb_vending_machine_multi;

    logic       clk;
    logic       rst;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       sel_valid;
    logic [1:0] sel_idx;
    logic       cancel;
    logic       restock;
    logic       vend_valid;
    logic [1:0] vend_idx;
    logic       change_valid;
    logic [1:0] change_coin;
    logic       coin_reject;
    logic       deny;
    logic       busy;
    logic [7:0] credit;
    logic [3:0] sold_out;

    vending_machine_multi dut (
        .clk(clk), .rst(rst),
        .coin_valid(coin_valid), .coin_type(coin_type),
        .sel_valid(sel_valid), .sel_idx(sel_idx),
        .cancel(cancel), .restock(restock),
        .vend_valid(vend_valid), .vend_idx(vend_idx),
        .change_valid(change_valid), .change_coin(change_coin),
        .coin_reject(coin_reject), .deny(deny), .busy(busy),
        .credit(credit), .sold_out(sold_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit isVend;
        int idx;
        int coin;
    } act_t;

    int   checks = 0;
    int   errors = 0;
    int   prices [4] = '{2, 3, 4, 5};
    int   mCredit;
    int   mStock [4];
    bit   mReject;
    bit   mDeny;
    act_t plan [$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int coinValue(input logic [1:0] t);
        return (t == 2'b00) ? 1 : (t == 2'b01) ? 2 : 5;
    endfunction

    function automatic logic [1:0] coinCode(input int v);
        return (v == 5) ? 2'b10 : (v == 2) ? 2'b01 : 2'b00;
    endfunction

    // Refund or change is paid greedily, largest coin first.
    function automatic void planChange(input int amount);
        act_t a;
        int c;
        c = amount;
        while (c > 0) begin
            a.isVend = 1'b0;
            a.idx    = 0;
            a.coin   = (c >= 5) ? 5 : (c >= 2) ? 2 : 1;
            c        = c - a.coin;
            plan.push_back(a);
        end
    endfunction

    task automatic modelReset();
        plan.delete();
        mCredit = 0;
        mReject = 1'b0;
        mDeny   = 1'b0;
        for (int i = 0; i < 4; i++) mStock[i] = 15;
    endtask

    task automatic modelStep(input bit cv, input logic [1:0] ct, input bit sv,
                             input logic [1:0] si, input bit ca, input bit rs);
        act_t a;
        mReject = 1'b0;
        mDeny   = 1'b0;
        if (plan.size() > 0) begin
            a = plan.pop_front();
            if (a.isVend) begin
                mCredit = mCredit - prices[a.idx];
                if (!rs) mStock[a.idx] = mStock[a.idx] - 1;
            end else begin
                mCredit = mCredit - a.coin;
            end
            mReject = cv;
        end else if (ca) begin
            if (mCredit > 0) planChange(mCredit);
            mReject = cv;
        end else if (sv) begin
            if (mCredit >= prices[si] && mStock[si] > 0) begin
                a.isVend = 1'b1;
                a.idx    = int'(si);
                a.coin   = 0;
                plan.push_back(a);
                planChange(mCredit - prices[si]);
            end else begin
                mDeny = 1'b1;
            end
            mReject = cv;
        end else if (cv) begin
            if (ct == 2'b11 || mCredit + coinValue(ct) > 40)
                mReject = 1'b1;
            else
                mCredit = mCredit + coinValue(ct);
        end
        if (rs)
            for (int i = 0; i < 4; i++) mStock[i] = 15;
    endtask

    task automatic checkAll();
        bit         ev;
        bit         ecv;
        int         ei;
        int         ec;
        logic [3:0] es;
        ev = 1'b0; ecv = 1'b0; ei = 0; ec = 0;
        if (plan.size() > 0) begin
            ev  = plan[0].isVend;
            ecv = !plan[0].isVend;
            ei  = plan[0].idx;
            ec  = plan[0].coin;
        end
        for (int i = 0; i < 4; i++) es[i] = (mStock[i] == 0);
        checkOutput("vend_valid", 32'(vend_valid), 32'(ev));
        if (ev) checkOutput("vend_idx", 32'(vend_idx), 32'(ei));
        checkOutput("change_valid", 32'(change_valid), 32'(ecv));
        if (ecv) checkOutput("change_coin", 32'(change_coin), 32'(coinCode(ec)));
        checkOutput("busy", 32'(busy), 32'(plan.size() > 0));
        checkOutput("credit", 32'(credit), 32'(mCredit));
        checkOutput("coin_reject", 32'(coin_reject), 32'(mReject));
        checkOutput("deny", 32'(deny), 32'(mDeny));
        checkOutput("sold_out", 32'(sold_out), 32'(es));
    endtask

    task automatic applyStimulus(input bit cv, input logic [1:0] ct, input bit sv,
                                 input logic [1:0] si, input bit ca, input bit rs);
        coin_valid = cv;
        coin_type  = ct;
        sel_valid  = sv;
        sel_idx    = si;
        cancel     = ca;
        restock    = rs;
        @(posedge clk);
        #1;
        modelStep(cv, ct, sv, si, ca, rs);
        checkAll();
    endtask

    task automatic insert(input logic [1:0] t);
        applyStimulus(1'b1, t, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic pick(input logic [1:0] i);
        applyStimulus(1'b0, 2'b00, 1'b1, i, 1'b0, 1'b0);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy && n < 20) begin
            idleCycle();
            n++;
        end
        checkOutput("drain_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        coin_valid = 1'b0; coin_type = 2'b00; sel_valid = 1'b0;
        sel_idx = 2'd0; cancel = 1'b0; restock = 1'b0;
        modelReset();
        #12;
        checkAll();
        rst = 1'b1;

        // 5,5 then item 0: exact payment, no change.
        insert(2'b00); insert(2'b00); pick(2'd0);
        checkOutput("t1_vend", 32'(vend_valid), 32'd1);
        idleCycle();
        checkOutput("t1_credit", 32'(credit), 32'd0);
        checkOutput("t1_nochange", 32'(change_valid), 32'd0);

        // 25 then item 1: one 10 coin change.
        insert(2'b10); pick(2'd1); idleCycle();
        checkOutput("t2_change", 32'(change_coin), 32'(2'b01));
        idleCycle();
        checkOutput("t2_credit", 32'(credit), 32'd0);

        // 25,25 then cancel, with a coin offered during the refund.
        insert(2'b10); insert(2'b10);
        applyStimulus(1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
        checkOutput("t3_reject", 32'(coin_reject), 32'd1);
        drain();

        // Insufficient credit, then credit ceiling.
        insert(2'b01); pick(2'd3);
        checkOutput("t4_credit", 32'(credit), 32'd2);
        applyStimulus(1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
        drain();
        for (int i = 0; i < 8; i++) insert(2'b10);
        checkOutput("t4_ceiling", 32'(credit), 32'd40);
        insert(2'b10);
        insert(2'b11);
        applyStimulus(1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
        drain();

        // Sell out item 0, then restock.
        for (int i = 0; i < 15; i++) begin
            insert(2'b01); pick(2'd0); idleCycle();
        end
        checkOutput("t5_soldout", 32'(sold_out[0]), 32'd1);
        insert(2'b01); pick(2'd0);
        applyStimulus(1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b1);
        checkOutput("t5_restock", 32'(sold_out[0]), 32'd0);
        applyStimulus(1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
        drain();

        // Asynchronous reset in the middle of a refund.
        insert(2'b10); insert(2'b10);
        applyStimulus(1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        modelReset();
        checkAll();
        checkOutput("t6_change_valid", 32'(change_valid), 32'd0);
        #2;
        rst = 1'b1;

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            int r;
            bit cv, sv, ca, rs;
            r  = int'($urandom_range(0, 99));
            ca = (r < 4);
            sv = (r >= 4 && r < 30);
            cv = (r >= 30 && r < 80) || ($urandom_range(0, 9) == 0);
            rs = ($urandom_range(0, 199) == 0);
            applyStimulus(cv, 2'($urandom_range(0, 3)), sv, 2'($urandom_range(0, 3)), ca, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
